mmio_mixer: RTL and testbench
=============================

Name: mmio_mixer

Overview:
- MMIO slot that mixes N_CH voice channels (DDFS-style PCM sources) into one PCM stream for the i2s DAC path.
- Each channel has a per-channel gain and an enable bit; a master gain and saturation are applied after summing.
- Sits between the voice slots and i2s_cdc. It converts the DAC's data-ready pulse into a sample-request pulse to all voices, collects their samples, and emits one mixed sample.
- Generalises the single-voice DDFS→i2s connection to N channels with gain, timeout and clip reporting.

Parameters:
- N_CH, 4, number of input channels (1..16).
- W, 16, PCM sample width, signed two's complement.
- TIMEOUT, 255, cycles to wait for channel samples before substituting 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  slot select
- read  in  1  MMIO read strobe
- write  in  1  MMIO write strobe
- addr  in  5  register address
- write_data  in  32  MMIO write data
- read_data  out  32  MMIO read data, combinational from addr
- ch_pcm  in  N_CH*W  channel samples; channel i occupies [i*W +: W]
- ch_valid  in  N_CH  channel sample-valid pulses
- ch_en  out  1  one-cycle sample-request pulse to all voices
- mix_ready  in  1  DAC ready for next sample (pulse)
- mix_out  out  W  mixed sample
- mix_valid  out  1  one-cycle pulse; mix_out is valid in that cycle

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: ch_en=0, mix_valid=0, mix_out=0, FSM=IDLE.
- Register reset values: all gains 0x8000, master 0x8000, enable mask 0, status 0, sample count 0.
- Register map (a write takes effect when cs&write):
  - addr 0..N_CH-1: GAIN[i], bits[15:0], unsigned; scale = gain/2^15 (0x8000 = 1.0).
  - addr 0x10: ENABLE mask, bits[N_CH-1:0].
  - addr 0x11: MASTER gain, bits[15:0], same format as GAIN.
  - addr 0x12: STATUS. Bit0 = clip sticky, bit1 = timeout sticky. Any write clears both bits.
  - addr 0x13: SAMPLE_CNT, 32-bit count of emitted samples, wraps at 2^32, read-only.
  - Unmapped addresses read as 0; writes to them are ignored.
- FSM states and transitions:
  - IDLE: on mix_ready=1, assert ch_en for 1 cycle, clear the got mask and timeout counter, go to WAIT.
  - WAIT: for each i with ch_valid[i], latch ch_pcm[i] and set got[i].
    - Disabled channels count as got.
    - When (got|~ENABLE) is all-ones, including a valid arriving in the current cycle, snapshot GAIN[] and MASTER and go to MAC.
    - The timeout counter increments each cycle. When it reaches TIMEOUT, missing channels contribute 0, the timeout sticky bit is set, and the FSM goes to MAC.
    - A repeated ch_valid for an already-got channel overwrites the latched sample.
  - MAC: one channel per cycle, i = 0..N_CH-1, so N_CH cycles.
    - acc += (pcm_i * gain_i) >>> 15, using a signed 17-bit gain.
    - acc width is W+2+clog2(N_CH); no overflow is possible in acc.
  - MASTER (1 cycle):
    - y = (acc * master) >>> 15, arithmetic shift, truncate toward −∞.
    - Saturate y to [-2^(W-1), 2^(W-1)-1]; if clamped, set the clip sticky bit.
  - OUT (1 cycle): mix_out=y, mix_valid=1, SAMPLE_CNT++, go to IDLE.
- mix_out holds its value between samples.
- mix_ready is ignored outside IDLE; no queuing.
- Latency: if the WAIT exit decision happens in cycle t, mix_valid=1 in cycle t+N_CH+2.
- ENABLE=0: WAIT exits the cycle after ch_en; output is 0.
- Register writes during WAIT/MAC/MASTER affect the next sample only, because gains are snapshotted at WAIT exit.
- reset mid-operation returns to IDLE in the next cycle, with all outputs at their reset values and no mix_valid.

Test Plan:
- Single channel: ENABLE=0x1, gains 0x8000, ch0 returns 0x1234 two cycles after ch_en → mix_out=0x1234, mix_valid exactly N_CH+2 cycles after capture, SAMPLE_CNT=1.
- Half gain: ch0=0x4000, GAIN0=0x4000 → mix_out=0x2000. With ch0=-3 → mix_out=-2 (floor).
- Saturation: ENABLE=0x3, ch0=ch1=0x7000 → mix_out=0x7FFF, STATUS=0x1. Write STATUS → reads 0. Negative case (0x9000 + 0x9000) → 0x8000.
- Timeout: ENABLE=0x3, only ch0 valid (0x0100) → mix_valid after TIMEOUT+N_CH+2 cycles from ch_en, mix_out=0x0100, STATUS bit1=1.
- Disabled channel and snapshot: ENABLE=0x1, ch1 asserts valid with 0x7FFF → ignored. Write GAIN0=0 during MAC → current sample unchanged, next sample 0.
- Reset mid-MAC: assert reset in the 2nd MAC cycle → no mix_valid, mix_out=0, SAMPLE_CNT=0. The next mix_ready produces ch_en normally.

Source files
------------

// File: rtl/mmio_mixer.sv
// mmio_mixer: MMIO slot that mixes N_CH voice channels into one PCM stream.
// On a DAC ready pulse it requests one sample from every voice, collects the
// replies (with a timeout), applies per-channel and master gain serially, then
// saturates and emits one mixed sample.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   cs, read, write       - MMIO slot select and strobes
//   addr, write_data      - MMIO register address / write data
//   read_data             - MMIO read data, combinational from addr
//   ch_pcm, ch_valid      - per-channel samples ([i*W +: W]) and valid pulses
//   ch_en                 - one-cycle sample request to all voices
//   mix_ready             - DAC ready pulse
//   mix_out, mix_valid    - mixed sample and its one-cycle valid pulse
module mmio_mixer #(
  parameter int N_CH    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  input  logic [N_CH*W-1:0] ch_pcm,
  input  logic [N_CH-1:0]   ch_valid,
  output logic              ch_en,
  input  logic              mix_ready,
  output logic [W-1:0]      mix_out,
  output logic              mix_valid
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W = W + 2 + $clog2(N_CH);
  localparam int TMO_W = $clog2(TIMEOUT + 2);
  localparam int MW    = ACC_W + 17;
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_MAC    = 3'd2,
    ST_MASTER = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  state_t state_r, state_next_s;

  logic [15:0]              gain_r [N_CH];
  logic [15:0]              gain_snap_r [N_CH];
  logic [15:0]              master_r, master_snap_r;
  logic [N_CH-1:0]          enable_r, got_r, use_r;
  logic [1:0]               status_r;
  logic [31:0]              sample_cnt_r;
  logic [W-1:0]             pcm_r [N_CH];
  logic [TMO_W-1:0]         tmo_cnt_r;
  logic [IDX_W-1:0]         mac_idx_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     ch_en_r, mix_valid_r;
  logic [W-1:0]             mix_out_r;

  logic [N_CH-1:0]          got_now_s;
  logic                     all_got_s, tmo_hit_s, wait_done_s;
  logic                     reg_wr_s, status_wr_s, clip_evt_s, tmo_evt_s;
  logic [W-1:0]             pcm_sel_s;
  logic [15:0]              gain_sel_s;
  logic signed [W+16:0]     prod_s, term_full_s;
  logic signed [W+1:0]      term_s;
  logic signed [MW-1:0]     mprod_s, y_full_s;
  logic [W-1:0]             y_s;
  logic                     clip_s;
  logic [31:0]              read_data_s;
  logic                     unused_s;

  // A valid arriving this cycle already counts; disabled channels never block.
  assign got_now_s   = got_r | ch_valid;
  assign all_got_s   = &(got_now_s | ~enable_r);
  assign tmo_hit_s   = (tmo_cnt_r == TMO_W'(TIMEOUT));
  assign wait_done_s = all_got_s || tmo_hit_s;
  assign reg_wr_s    = cs & write;
  assign status_wr_s = reg_wr_s && (addr == 5'h12);
  assign clip_evt_s  = (state_r == ST_MASTER) && clip_s;
  assign tmo_evt_s   = (state_r == ST_WAIT) && !all_got_s && tmo_hit_s;
  assign unused_s    = &{1'b0, read, write_data[31:16]};

  // Next-state decode for the request/collect/mac/master/out sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   if (mix_ready) state_next_s = ST_WAIT; else state_next_s = ST_IDLE;
      ST_WAIT:   if (wait_done_s) state_next_s = ST_MAC; else state_next_s = ST_WAIT;
      ST_MAC:    if (mac_idx_r == IDX_W'(N_CH - 1)) state_next_s = ST_MASTER;
                 else state_next_s = ST_MAC;
      ST_MASTER: state_next_s = ST_OUT;
      ST_OUT:    state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Per-channel gain term; channels that were disabled or missing add zero.
  always_comb begin
    pcm_sel_s   = pcm_r[mac_idx_r];
    gain_sel_s  = gain_snap_r[mac_idx_r];
    prod_s      = (W+17)'($signed(pcm_sel_s)) * (W+17)'($signed({1'b0, gain_sel_s}));
    term_full_s = prod_s >>> 5'd15;
    if (use_r[mac_idx_r]) term_s = $signed(term_full_s[W+1:0]);
    else                  term_s = {(W+2){1'b0}};
  end

  // Master gain with floor shift, then clamp to the W-bit signed range.
  always_comb begin
    mprod_s  = MW'(acc_r) * MW'($signed({1'b0, master_snap_r}));
    y_full_s = mprod_s >>> 5'd15;
    if (y_full_s > SAT_MAX) begin
      y_s    = {1'b0, {(W-1){1'b1}}};
      clip_s = 1'b1;
    end else if (y_full_s < SAT_MIN) begin
      y_s    = {1'b1, {(W-1){1'b0}}};
      clip_s = 1'b1;
    end else begin
      y_s    = y_full_s[W-1:0];
      clip_s = 1'b0;
    end
  end

  // MMIO read mux; unmapped addresses read as zero.
  always_comb begin
    read_data_s = 32'd0;
    case (addr)
      5'h10:   read_data_s = {{(32-N_CH){1'b0}}, enable_r};
      5'h11:   read_data_s = {16'd0, master_r};
      5'h12:   read_data_s = {30'd0, status_r};
      5'h13:   read_data_s = sample_cnt_r;
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          read_data_s = (addr == 5'(i)) ? {16'd0, gain_r[i]} : read_data_s;
        end
      end
    endcase
  end

  // Software-visible registers, sticky status and emitted-sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) gain_r[i] <= 16'h8000;
      master_r     <= 16'h8000;
      enable_r     <= {N_CH{1'b0}};
      status_r     <= 2'b00;
      sample_cnt_r <= 32'd0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (reg_wr_s && (addr == 5'(i))) gain_r[i] <= write_data[15:0];
      end
      if (reg_wr_s && (addr == 5'h10)) enable_r <= write_data[N_CH-1:0];
      if (reg_wr_s && (addr == 5'h11)) master_r <= write_data[15:0];
      // A status write clears first; an event in the same cycle still sets.
      status_r <= (status_wr_s ? 2'b00 : status_r) | {tmo_evt_s, clip_evt_s};
      if (state_r == ST_OUT) sample_cnt_r <= sample_cnt_r + 32'd1;
    end
  end

  // Sequencer state, sample capture, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ch_en_r       <= 1'b0;
      mix_valid_r   <= 1'b0;
      mix_out_r     <= {W{1'b0}};
      got_r         <= {N_CH{1'b0}};
      use_r         <= {N_CH{1'b0}};
      tmo_cnt_r     <= {TMO_W{1'b0}};
      mac_idx_r     <= {IDX_W{1'b0}};
      acc_r         <= {ACC_W{1'b0}};
      master_snap_r <= 16'h8000;
      for (int i = 0; i < N_CH; i++) begin
        pcm_r[i]       <= {W{1'b0}};
        gain_snap_r[i] <= 16'h8000;
      end
    end else begin
      state_r     <= state_next_s;
      ch_en_r     <= (state_r == ST_IDLE) && mix_ready;
      mix_valid_r <= (state_r == ST_MASTER);
      case (state_r)
        ST_IDLE: begin
          if (mix_ready) begin
            got_r     <= {N_CH{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
          end
        end
        ST_WAIT: begin
          for (int i = 0; i < N_CH; i++) begin
            if (ch_valid[i]) pcm_r[i] <= ch_pcm[i*W +: W];
          end
          got_r     <= got_now_s;
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
          if (wait_done_s) begin
            // Gains are frozen here so later writes only affect the next sample.
            gain_snap_r   <= gain_r;
            master_snap_r <= master_r;
            use_r         <= got_now_s & enable_r;
            acc_r         <= {ACC_W{1'b0}};
            mac_idx_r     <= {IDX_W{1'b0}};
          end
        end
        ST_MAC: begin
          acc_r     <= acc_r + ACC_W'(term_s);
          mac_idx_r <= mac_idx_r + IDX_W'(1'b1);
        end
        ST_MASTER: mix_out_r <= y_s;
        ST_OUT:    ;
        default:   ;
      endcase
    end
  end

  assign read_data = read_data_s;
  assign ch_en     = ch_en_r;
  assign mix_out   = mix_out_r;
  assign mix_valid = mix_valid_r;

endmodule

// File: tb/tb_mmio_mixer.sv
// Self-checking bench for mmio_mixer: expected samples are queued when a
// request is launched and popped when mix_valid is observed.
module tb_mmio_mixer;

  localparam int N_CH = 4;
  localparam int W = 16;
  localparam int TIMEOUT = 255;
  localparam int LAT = N_CH + 2;

  logic              clk = 1'b0;
  logic              reset, cs, read, write, mix_ready, ch_en, mix_valid;
  logic [4:0]        addr;
  logic [31:0]       write_data, read_data;
  logic [N_CH*W-1:0] ch_pcm;
  logic [N_CH-1:0]   ch_valid;
  logic [W-1:0]      mix_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          obs_cyc_q[$];

  mmio_mixer #(.N_CH(N_CH), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .ch_pcm(ch_pcm), .ch_valid(ch_valid), .ch_en(ch_en),
    .mix_ready(mix_ready), .mix_out(mix_out), .mix_valid(mix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: capture every emitted sample and the cycle it appeared in.
  always @(negedge clk) begin
    if (mix_valid === 1'b1) begin
      obs_q.push_back(mix_out);
      obs_cyc_q.push_back(cyc);
      n_valid++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; write_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    d = read_data;
    cs = 1'b0; read = 1'b0;
  endtask

  // Pulse mix_ready, find the ch_en cycle c0, then present vmask/pcm 'delay'
  // cycles later (cap = capture cycle). Returns one cycle after the capture.
  task automatic start_sample(input logic [N_CH-1:0] vmask, input logic [N_CH*W-1:0] pcm,
                              input int delay, output int c0, output int cap);
    tick();
    mix_ready = 1'b1;
    tick();
    mix_ready = 1'b0;
    c0 = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ch_en === 1'b1) begin
        c0 = cyc;
        break;
      end
    end
    for (int k = 0; k < delay; k++) tick();
    cap = (c0 < 0) ? -1 : c0;
    if (vmask != {N_CH{1'b0}}) begin
      ch_valid = vmask;
      ch_pcm = pcm;
      cap = cyc;
      tick();
      ch_valid = {N_CH{1'b0}};
    end
  endtask

  // Bounded wait for the next observed sample; X / -1 when none arrived.
  task automatic get_obs(input int budget, output logic [15:0] val, output int oc);
    val = {16{1'bx}};
    oc = -1;
    for (int k = 0; k < budget; k++) begin
      if (obs_q.size() > 0) begin
        val = obs_q.pop_front();
        oc = obs_cyc_q.pop_front();
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [10] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h1F};
    logic [31:0] exps  [10] = '{32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h0, 32'h8000,
                                32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ch_en, mix_valid, mix_out} !== {1'b0, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got ch_en=%b mix_valid=%b mix_out=%h, need 0/0/0000",
               ch_en, mix_valid, mix_out);
    end
    for (int i = 0; i < 10; i++) begin
      reg_read(addrs[i], rd);
      n_cmp++;
      if (rd !== exps[i]) begin
        n_bad++;
        $display("FAIL reset_reg[%h]: got %h, need %h", addrs[i], rd, exps[i]);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] v, e;
    logic [31:0] rd;
    int c0, cap, oc;
    reg_write(5'h10, 32'h1);
    exp_q.push_back(16'h1234);
    start_sample(4'h1, {48'h0, 16'h1234}, 2, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL single_out: got %h, need %h", v, e); end
    n_cmp++;
    if (oc !== cap + LAT) begin
      n_bad++;
      $display("FAIL single_latency: valid at cycle %0d, need %0d", oc, cap + LAT);
    end
    tick();
    reg_read(5'h13, rd);
    n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL single_cnt: got %0d, need 1", rd); end
  endtask

  task automatic test_half_gain();
    logic [15:0] v, e;
    int c0, cap, oc;
    reg_write(5'h00, 32'h4000);
    exp_q.push_back(16'h2000);
    start_sample(4'h1, {48'h0, 16'h4000}, 1, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL half_gain: got %h, need %h", v, e); end
    exp_q.push_back(16'hFFFE);
    start_sample(4'h1, {48'h0, 16'hFFFD}, 1, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL half_gain_floor: got %h, need %h", v, e); end
    reg_write(5'h00, 32'h8000);
  endtask

  task automatic test_four_mix();
    logic [15:0] v, e;
    logic [31:0] rd;
    int c0, cap, oc;
    reg_write(5'h10, 32'hF);
    reg_write(5'h11, 32'h4000);
    // (0x1000 + 0x0200 - 0x0100 + 0x0030) * 0.5 = 0x0898
    exp_q.push_back(16'h0898);
    start_sample(4'hF, {16'h0030, 16'hFF00, 16'h0200, 16'h1000}, 3, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL four_mix: got %h, need %h", v, e); end
    reg_read(5'h12, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL four_mix_status: got %h, need 0", rd); end
    reg_write(5'h11, 32'h8000);
  endtask

  task automatic test_saturation();
    logic [15:0] v, e;
    logic [31:0] rd;
    int c0, cap, oc;
    reg_write(5'h10, 32'h3);
    exp_q.push_back(16'h7FFF);
    start_sample(4'h3, {32'h0, 16'h7000, 16'h7000}, 1, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL sat_pos: got %h, need %h", v, e); end
    reg_read(5'h12, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_bad++; $display("FAIL sat_status: got %h, need 1", rd); end
    reg_write(5'h12, 32'h0);
    reg_read(5'h12, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL sat_status_clear: got %h, need 0", rd); end
    exp_q.push_back(16'h8000);
    start_sample(4'h3, {32'h0, 16'h9000, 16'h9000}, 2, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL sat_neg: got %h, need %h", v, e); end
    reg_write(5'h12, 32'h0);
  endtask

  task automatic test_timeout();
    logic [15:0] v, e;
    logic [31:0] rd;
    int c0, cap, oc;
    reg_write(5'h10, 32'h3);
    exp_q.push_back(16'h0100);
    start_sample(4'h1, {48'h0, 16'h0100}, 1, c0, cap);
    get_obs(TIMEOUT + 60, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL timeout_out: got %h, need %h", v, e); end
    n_cmp++;
    if (oc !== c0 + TIMEOUT + LAT) begin
      n_bad++;
      $display("FAIL timeout_latency: valid at cycle %0d, need %0d", oc, c0 + TIMEOUT + LAT);
    end
    reg_read(5'h12, rd);
    n_cmp++;
    if (rd !== 32'h2) begin n_bad++; $display("FAIL timeout_status: got %h, need 2", rd); end
    reg_write(5'h12, 32'h0);
  endtask

  task automatic test_snapshot();
    logic [15:0] v, e;
    int c0, cap, oc;
    reg_write(5'h10, 32'h1);
    exp_q.push_back(16'h0500);
    start_sample(4'h3, {32'h0, 16'h7FFF, 16'h0500}, 1, c0, cap);
    reg_write(5'h00, 32'h0);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL snapshot_cur: got %h, need %h", v, e); end
    exp_q.push_back(16'h0000);
    start_sample(4'h1, {48'h0, 16'h0500}, 1, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL snapshot_next: got %h, need %h", v, e); end
    reg_write(5'h00, 32'h8000);
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] v, e;
    logic [31:0] rd;
    int c0, cap, oc, nv;
    reg_write(5'h10, 32'h1);
    exp_q.push_back(16'h0777);
    start_sample(4'h1, {48'h0, 16'h0777}, 1, c0, cap);
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL pre_reset_out: got %h, need %h", v, e); end
    nv = n_valid;
    start_sample(4'h1, {48'h0, 16'h0333}, 1, c0, cap);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_valid !== nv) begin
      n_bad++;
      $display("FAIL midreset_no_valid: saw %0d pulses, need 0", n_valid - nv);
    end
    n_cmp++;
    if ({ch_en, mix_valid, mix_out} !== {1'b0, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL midreset_outputs: got ch_en=%b mix_valid=%b mix_out=%h, need 0/0/0000",
               ch_en, mix_valid, mix_out);
    end
    reg_read(5'h13, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL midreset_cnt: got %0d, need 0", rd); end
    // After reset ENABLE is 0, so WAIT exits immediately and the output is 0.
    exp_q.push_back(16'h0000);
    start_sample(4'h0, {64{1'b0}}, 0, c0, cap);
    n_cmp++;
    if (c0 < 0) begin n_bad++; $display("FAIL post_reset_ch_en: got no pulse, need one"); end
    get_obs(40, v, oc);
    e = exp_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_bad++; $display("FAIL enable0_out: got %h, need %h", v, e); end
    n_cmp++;
    if (oc !== c0 + LAT) begin
      n_bad++;
      $display("FAIL enable0_latency: valid at cycle %0d, need %0d", oc, c0 + LAT);
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; mix_ready = 1'b0;
    addr = 5'h0; write_data = 32'h0; ch_pcm = {(N_CH*W){1'b0}}; ch_valid = {N_CH{1'b0}};
    test_reset();
    test_single();
    test_half_gain();
    test_four_mix();
    test_saturation();
    test_timeout();
    test_snapshot();
    test_reset_mid_mac();
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL unexpected_samples: got %0d extra, need 0", obs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
